// File: rtl/led_pattern_gen.sv
// Multi-channel LED indicator engine: a shared prescaled tick times per-channel
// OFF / ON / BLINK / BURST / ONESHOT patterns, each reconfigurable at runtime.
module led_pattern_gen #(
  parameter int CHANNELS = 2,
  parameter int PRESCALE = 30,
  parameter int HALF_W   = 8,
  parameter int BURST_W  = 4
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_cfg_we,
  input  logic [3:0]          i_cfg_ch,
  input  logic [2:0]          i_cfg_mode,
  input  logic [HALF_W-1:0]   i_cfg_half,
  input  logic [BURST_W-1:0]  i_cfg_burst,
  input  logic [CHANNELS-1:0] i_trig,
  output logic [CHANNELS-1:0] o_led,
  output logic [CHANNELS-1:0] o_busy,
  output logic                o_tick
);

  localparam int PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int CNT_W = HALF_W + 2;

  localparam logic [2:0] M_ON      = 3'd1;
  localparam logic [2:0] M_BLINK   = 3'd2;
  localparam logic [2:0] M_BURST   = 3'd3;
  localparam logic [2:0] M_ONESHOT = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE, S_ON, S_BLINK, S_P_ON, S_P_OFF, S_GAP, S_OS_ACT
  } state_t;

  logic [PS_W-1:0] ps_cnt;
  logic            tick;

  // Shared prescaler; tick is registered so it lines up with o_tick.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ps_cnt <= '0;
      tick   <= 1'b0;
    end else if (ps_cnt == PS_W'(PRESCALE - 1)) begin
      ps_cnt <= '0;
      tick   <= 1'b1;
    end else begin
      ps_cnt <= ps_cnt + PS_W'(1);
      tick   <= 1'b0;
    end
  end

  assign o_tick = tick;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [2:0]         mode_q,  mode_d;
    logic [HALF_W-1:0]  half_q,  half_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [BURST_W-1:0] pcnt_q,  pcnt_d;
    state_t             st_q,    st_d;
    logic               led_q,   led_d;
    logic               busy_q,  busy_d;

    logic               wr;
    logic [CNT_W-1:0]   ph_end;
    logic [CNT_W-1:0]   gap_end;
    logic [BURST_W-1:0] b_eff;
    logic [BURST_W-1:0] pcnt_inc;

    assign wr       = i_cfg_we && (i_cfg_ch == 4'(g));
    assign ph_end   = {2'b00, half_q};
    // Gap lasts 4*(H+1) ticks, so its last count is 4H+3.
    assign gap_end  = {half_q, 2'b11};
    assign b_eff    = (burst_q == '0) ? BURST_W'(1) : burst_q;
    assign pcnt_inc = pcnt_q + BURST_W'(1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        mode_q  <= '0;
        half_q  <= '0;
        burst_q <= '0;
        cnt_q   <= '0;
        pcnt_q  <= '0;
        st_q    <= S_IDLE;
        led_q   <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        mode_q  <= mode_d;
        half_q  <= half_d;
        burst_q <= burst_d;
        cnt_q   <= cnt_d;
        pcnt_q  <= pcnt_d;
        st_q    <= st_d;
        led_q   <= led_d;
        busy_q  <= busy_d;
      end
    end

    // A config write overrides any tick or trigger seen in the same cycle.
    always_comb begin
      mode_d  = mode_q;
      half_d  = half_q;
      burst_d = burst_q;
      cnt_d   = cnt_q;
      pcnt_d  = pcnt_q;
      st_d    = st_q;
      led_d   = led_q;
      busy_d  = busy_q;
      if (wr) begin
        mode_d  = i_cfg_mode;
        half_d  = i_cfg_half;
        burst_d = i_cfg_burst;
        cnt_d   = '0;
        pcnt_d  = '0;
        st_d    = S_IDLE;
        led_d   = 1'b0;
        busy_d  = 1'b0;
        case (i_cfg_mode)
          M_ON:    begin st_d = S_ON;    led_d = 1'b1; end
          M_BLINK: begin st_d = S_BLINK; led_d = 1'b1; end
          M_BURST: begin st_d = S_P_ON;  led_d = 1'b1; busy_d = 1'b1; end
          default: ;
        endcase
      end else begin
        case (st_q)
          S_IDLE: begin
            if (mode_q == M_ONESHOT && i_trig[g]) begin
              st_d   = S_OS_ACT;
              led_d  = 1'b1;
              busy_d = 1'b1;
              cnt_d  = '0;
            end
          end
          S_BLINK: begin
            if (tick) begin
              if (cnt_q == ph_end) begin
                led_d = ~led_q;
                cnt_d = '0;
              end else begin
                cnt_d = cnt_q + CNT_W'(1);
              end
            end
          end
          S_P_ON: begin
            if (tick) begin
              if (cnt_q == ph_end) begin
                st_d  = S_P_OFF;
                led_d = 1'b0;
                cnt_d = '0;
              end else begin
                cnt_d = cnt_q + CNT_W'(1);
              end
            end
          end
          S_P_OFF: begin
            if (tick) begin
              if (cnt_q == ph_end) begin
                cnt_d = '0;
                if (pcnt_inc == b_eff) begin
                  st_d   = S_GAP;
                  busy_d = 1'b0;
                  pcnt_d = '0;
                end else begin
                  st_d   = S_P_ON;
                  led_d  = 1'b1;
                  pcnt_d = pcnt_inc;
                end
              end else begin
                cnt_d = cnt_q + CNT_W'(1);
              end
            end
          end
          S_GAP: begin
            if (tick) begin
              if (cnt_q == gap_end) begin
                st_d   = S_P_ON;
                led_d  = 1'b1;
                busy_d = 1'b1;
                cnt_d  = '0;
              end else begin
                cnt_d = cnt_q + CNT_W'(1);
              end
            end
          end
          S_OS_ACT: begin
            // Retrigger restarts the pulse, even on the final tick.
            if (i_trig[g]) begin
              cnt_d = '0;
            end else if (tick) begin
              if (cnt_q == ph_end) begin
                st_d   = S_IDLE;
                led_d  = 1'b0;
                busy_d = 1'b0;
                cnt_d  = '0;
              end else begin
                cnt_d = cnt_q + CNT_W'(1);
              end
            end
          end
          default: ;
        endcase
      end
    end

    assign o_led[g]  = led_q;
    assign o_busy[g] = busy_q;
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: directed and randomized config/trigger traffic
// checked every cycle against a tick-count based reference model.
module tb_led_pattern_gen;
  localparam int CH = 2;
  localparam int PS = 30;
  localparam int HW = 8;
  localparam int BW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          cfg_we = 1'b0;
  logic [3:0]    cfg_ch = '0;
  logic [2:0]    cfg_mode = '0;
  logic [HW-1:0] cfg_half = '0;
  logic [BW-1:0] cfg_burst = '0;
  logic [CH-1:0] trig = '0;
  logic [CH-1:0] led;
  logic [CH-1:0] busy;
  logic          tick;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  led_pattern_gen #(.CHANNELS(CH), .PRESCALE(PS), .HALF_W(HW), .BURST_W(BW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_cfg_we(cfg_we), .i_cfg_ch(cfg_ch),
    .i_cfg_mode(cfg_mode), .i_cfg_half(cfg_half), .i_cfg_burst(cfg_burst),
    .i_trig(trig), .o_led(led), .o_busy(busy), .o_tick(tick)
  );

  // Reference model: cycles since reset, ticks since config, one-shot age.
  int m_cyc;
  int m_mode[CH];
  int m_h[CH];
  int m_b[CH];
  int m_ticks[CH];
  bit m_act[CH];
  int m_t[CH];

  function automatic void model_reset();
    m_cyc = 0;
    for (int c = 0; c < CH; c++) begin
      m_mode[c] = 0; m_h[c] = 0; m_b[c] = 0;
      m_ticks[c] = 0; m_act[c] = 0; m_t[c] = 0;
    end
  endfunction

  function automatic bit m_tick();
    return (m_cyc > 0) && (m_cyc % PS == 0);
  endfunction

  function automatic void model_edge();
    bit tk;
    tk = m_tick();
    for (int c = 0; c < CH; c++) begin
      if (cfg_we && int'(cfg_ch) == c) begin
        m_mode[c] = int'(cfg_mode); m_h[c] = int'(cfg_half); m_b[c] = int'(cfg_burst);
        m_ticks[c] = 0; m_act[c] = 0; m_t[c] = 0;
      end else begin
        if (tk) m_ticks[c]++;
        if (m_mode[c] == 4) begin
          if (trig[c]) begin
            m_act[c] = 1; m_t[c] = 0;
          end else if (m_act[c] && tk) begin
            m_t[c]++;
            if (m_t[c] == m_h[c] + 1) m_act[c] = 0;
          end
        end
      end
    end
    m_cyc++;
  endfunction

  function automatic void expect_ch(input int c, output bit el, output bit eb);
    int u, b, ph;
    u = m_h[c] + 1;
    b = (m_b[c] == 0) ? 1 : m_b[c];
    el = 0; eb = 0;
    case (m_mode[c])
      1: el = 1;
      2: el = ((m_ticks[c] / u) % 2) == 0;
      3: begin
        ph = (m_ticks[c] % ((2 * b + 4) * u)) / u;
        if (ph < 2 * b) begin
          el = (ph % 2) == 0;
          eb = 1;
        end
      end
      4: begin el = m_act[c]; eb = m_act[c]; end
      default: ;
    endcase
  endfunction

  task automatic check(input string tag);
    logic [CH-1:0] el, eb;
    bit a, b;
    logic et;
    for (int c = 0; c < CH; c++) begin
      expect_ch(c, a, b);
      el[c] = a;
      eb[c] = b;
    end
    et = m_tick();
    vectors++;
    assert (led === el) else begin
      miscompares++;
      $error("FAIL %s led obs=%b exp=%b cyc=%0d", tag, led, el, m_cyc);
    end
    assert (busy === eb) else begin
      miscompares++;
      $error("FAIL %s busy obs=%b exp=%b cyc=%0d", tag, busy, eb, m_cyc);
    end
    assert (tick === et) else begin
      miscompares++;
      $error("FAIL %s tick obs=%b exp=%b cyc=%0d", tag, tick, et, m_cyc);
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check(tag);
  endtask

  task automatic run(input int n, input string tag, input bit rnd_trig);
    for (int i = 0; i < n; i++) begin
      if (rnd_trig) trig = ($urandom_range(0, 19) == 0) ? CH'($urandom) : '0;
      step(tag);
    end
    trig = '0;
  endtask

  task automatic write(input int ch, input int mode, input int half, input int burst);
    cfg_we = 1'b1;
    cfg_ch = 4'(ch);
    cfg_mode = 3'(mode);
    cfg_half = HW'(half);
    cfg_burst = BW'(burst);
    step("cfg");
    cfg_we = 1'b0;
  endtask

  initial begin
    model_reset();
    #1 rst_n = 1'b0;
    #1 check("reset");
    @(negedge clk);
    rst_n = 1'b1;
    run(100, "idle", 1'b0);

    write(0, 2, 0, 0);
    run(100, "blink_h0", 1'b0);
    write(1, 1, 0, 0);
    run(100, "on_ch1", 1'b1);

    write(0, 3, 1, 3);
    run(650, "burst_b3", 1'b1);
    write(0, 3, 1, 0);
    run(400, "burst_b0", 1'b0);

    write(1, 4, 2, 0);
    trig = 2'b10;
    step("os_trig");
    trig = '0;
    run(60, "os_run", 1'b0);
    trig = 2'b10;
    step("os_retrig");
    trig = '0;
    run(120, "os_ext", 1'b0);
    run(800, "os_rand", 1'b1);

    write(5, 1, 3, 3);
    run(40, "bad_ch", 1'b0);

    // Align so the next config write lands on a tick cycle.
    for (int i = 0; i < PS + 1 && !m_tick(); i++) step("align");
    write(0, 2, $urandom_range(0, 3), 0);
    run(200, "blink_tickwr", 1'b0);

    for (int k = 0; k < 30; k++) begin
      write($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3),
            $urandom_range(0, 15));
      run($urandom_range(20, 300), "rand", 1'b1);
    end

    write(0, 3, 1, 3);
    write(1, 4, 0, 0);
    run(100, "pre_rst", 1'b1);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check("async_rst");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run(100, "post_rst", 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
